// File: rtl/vga_adapter_pkg.sv
// Constants and row-packer FSM encoding shared by the capture stage, the row packer and the display reader.
// Keep in step with the frame-memory map: a row occupies WORDS_PER_ROW consecutive words starting at row*WORDS_PER_ROW.
package vga_adapter_pkg;

  localparam int ROW_BITS      = 320;
  localparam int IDX_W         = 8;
  localparam int WORD_W        = 16;
  localparam int WORDS_PER_ROW = ROW_BITS / WORD_W;
  localparam int MAX_ROWS      = 240;
  localparam int ADDR_W        = 13;
  localparam int DROP_W        = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } pk_state_e;

endpackage

// File: rtl/row_packer_if.sv
// Frame-memory write port: master drives a word write request, slave answers with mem_ready.
// A write completes on any clock edge where mem_we and mem_ready are both high.
interface row_packer_if #(
  parameter int ADDR_W = vga_adapter_pkg::ADDR_W,
  parameter int WORD_W = vga_adapter_pkg::WORD_W
) ();
  import vga_adapter_pkg::*;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_ready;

  modport master (output mem_we, output mem_addr, output mem_wdata, input mem_ready);
  modport slave  (input mem_we, input mem_addr, input mem_wdata, output mem_ready);

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchroniser plus registered rising-edge pulse; pulse is high on the 3rd clk after the async rise.
// An input already high when reset releases must be seen low once before any pulse (armed_q).
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic edge_o
);
  import vga_adapter_pkg::*;

  logic ff1_q, ff1_d;
  logic ff2_q, ff2_d;
  logic ff3_q, ff3_d;
  logic fill_q, fill_d;
  logic armed_q, armed_d;
  logic pulse_q, pulse_d;

  always_comb begin
    ff1_d   = async_i;
    ff2_d   = ff1_q;
    ff3_d   = ff2_q;
    fill_d  = 1'b1;
    // ff1_q holds a real sample only once fill_q is set; arm on the first genuine low
    armed_d = armed_q | (fill_q & ~ff1_q);
    pulse_d = ff2_q & ~ff3_q & armed_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1_q   <= 1'b0;
      ff2_q   <= 1'b0;
      ff3_q   <= 1'b0;
      fill_q  <= 1'b0;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      ff1_q   <= ff1_d;
      ff2_q   <= ff2_d;
      ff3_q   <= ff3_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
      pulse_q <= pulse_d;
    end
  end

  assign edge_o = pulse_q;

endmodule

// File: rtl/row_packer.sv
// Snapshots a completed capture row and writes it to frame memory as WORDS_PER_ROW words (edge +1 LATCH, then 1 word/clk while mem_ready).
// Stalls hold addr/data stable; edges arriving while not IDLE are dropped and flagged. ROW_PACKER_DROP_CNT_EN adds drop_count.
module row_packer #(
  parameter int ROW_BITS = vga_adapter_pkg::ROW_BITS,
  parameter int IDX_W    = vga_adapter_pkg::IDX_W,
  parameter int WORD_W   = vga_adapter_pkg::WORD_W,
  parameter int MAX_ROWS = vga_adapter_pkg::MAX_ROWS,
  parameter int ADDR_W   = vga_adapter_pkg::ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                row_ready,
  input  logic [IDX_W-1:0]    row_index,
  input  logic [ROW_BITS-1:0] row_data,
  row_packer_if.master        mem,
  output logic                busy,
  output logic                row_done,
  output logic                overrun
`ifdef ROW_PACKER_DROP_CNT_EN
  ,
  output logic [7:0]          drop_count
`endif
);
  import vga_adapter_pkg::*;

  localparam int                WPR    = ROW_BITS / WORD_W;
  localparam int                K_W    = $clog2(WPR);
  localparam logic [ADDR_W-1:0] WPR_A  = ADDR_W'(WPR);
  localparam logic [K_W-1:0]    K_LAST = K_W'(WPR - 1);

  logic row_edge;
  logic drop_evt;

  pk_state_e                     state_q, state_d;
  logic [WPR-1:0][WORD_W-1:0]    snap_q, snap_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [ADDR_W-1:0]             base_q, base_d;
  logic [K_W-1:0]                k_q, k_d;
  logic                          overrun_q, overrun_d;

  sync_edge u_sync_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (row_ready),
    .edge_o  (row_edge)
  );

  assign drop_evt = row_edge & (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    idx_d     = idx_q;
    base_d    = base_q;
    k_d       = k_q;
    overrun_d = overrun_q | drop_evt;

    case (state_q)
      ST_IDLE: begin
        if (row_edge) begin
          snap_d  = row_data;
          idx_d   = row_index;
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (int'(idx_q) >= MAX_ROWS) begin
          state_d = ST_IDLE;
        end else begin
          base_d  = ADDR_W'(idx_q) * WPR_A;
          k_d     = '0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (mem.mem_ready) begin
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = ST_DONE;
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Address and data are forced to zero outside WRITE so the port is quiet between rows
  always_comb begin
    mem.mem_we    = (state_q == ST_WRITE);
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    if (state_q == ST_WRITE) begin
      mem.mem_addr  = base_q + ADDR_W'(k_q);
      mem.mem_wdata = snap_q[k_q];
    end
  end

  // busy also covers the cycle the accepted edge is seen, so a discarded row reads busy for two clocks
  assign busy     = (state_q != ST_IDLE) | row_edge;
  assign row_done = (state_q == ST_DONE);
  assign overrun  = overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      snap_q    <= '0;
      idx_q     <= '0;
      base_q    <= '0;
      k_q       <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      idx_q     <= idx_d;
      base_q    <= base_d;
      k_q       <= k_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef ROW_PACKER_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (drop_evt && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= 8'd0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_row_packer.sv
// Directed bench for row_packer: memory-port monitor with stall-hold tracking, hand-computed rows and addresses.
module tb_row_packer;
  import vga_adapter_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         row_ready;
  logic [7:0]   row_index;
  logic [319:0] row_data;
  logic         busy;
  logic         row_done;
  logic         overrun;
`ifdef ROW_PACKER_DROP_CNT_EN
  logic [7:0]   drop_count;
`endif

  always #5 clk = ~clk;

  row_packer_if mem_if ();

  row_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .row_ready  (row_ready),
    .row_index  (row_index),
    .row_data   (row_data),
    .mem        (mem_if.master),
    .busy       (busy),
    .row_done   (row_done),
    .overrun    (overrun)
`ifdef ROW_PACKER_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [12:0] cap_addr[$];
  logic [15:0] cap_data[$];
  int          done_cnt = 0;
  int          busy_cnt = 0;
  int          hold_err = 0;
  bit          rnd_rdy  = 1'b0;
  logic        rdy_val  = 1'b1;
  logic        stalled  = 1'b0;
  logic [12:0] st_addr;
  logic [15:0] st_data;

  // mem_ready is updated first, so the accept decision describes the next rising edge
  always @(negedge clk) begin
    mem_if.mem_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_val;
    if (stalled && mem_if.mem_we &&
        (mem_if.mem_addr !== st_addr || mem_if.mem_wdata !== st_data))
      hold_err++;
    stalled = mem_if.mem_we && !mem_if.mem_ready;
    st_addr = mem_if.mem_addr;
    st_data = mem_if.mem_wdata;
    if (mem_if.mem_we && mem_if.mem_ready) begin
      cap_addr.push_back(mem_if.mem_addr);
      cap_data.push_back(mem_if.mem_wdata);
    end
    if (row_done) done_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [319:0] mk_row(input logic [15:0] b);
    logic [319:0] r;
    for (int j = 0; j < 20; j++) r[j*16 +: 16] = b + 16'(j);
    return r;
  endfunction

  function automatic logic [319:0] alt_row();
    logic [319:0] r;
    for (int k = 0; k < 320; k++) r[k] = 1'(k % 2);
    return r;
  endfunction

  task automatic clear_mon();
    cap_addr.delete();
    cap_data.delete();
    done_cnt = 0;
    busy_cnt = 0;
    hold_err = 0;
  endtask

  task automatic row_go(input logic [7:0] idx, input logic [319:0] d);
    @(posedge clk); #1;
    row_index = idx;
    row_data  = d;
    row_ready = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    repeat (6) begin @(posedge clk); #1; end
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    row_ready = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic chk_row(input string tag, input int base, input logic [319:0] d);
    logic [15:0] w;
    chk({tag, "_nwr"}, 32'(cap_addr.size()), 32'd20);
    for (int j = 0; j < 20; j++) begin
      if (j < cap_addr.size()) begin
        w = d[j*16 +: 16];
        chk($sformatf("%s_addr%0d", tag, j), 32'(cap_addr[j]), 32'(base + j));
        chk($sformatf("%s_data%0d", tag, j), 32'(cap_data[j]), 32'(w));
      end
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_we"},    32'(mem_if.mem_we),    32'd0);
    chk({tag, "_addr"},  32'(mem_if.mem_addr),  32'd0);
    chk({tag, "_wdata"}, 32'(mem_if.mem_wdata), 32'd0);
    chk({tag, "_busy"},  32'(busy),             32'd0);
    chk({tag, "_done"},  32'(row_done),         32'd0);
    chk({tag, "_ovr"},   32'(overrun),          32'd0);
`ifdef ROW_PACKER_DROP_CNT_EN
    chk({tag, "_drop"},  32'(drop_count),       32'd0);
`endif
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    row_ready = 1'b0;
    row_index = '0;
    row_data  = '0;

    #12;
    chk_quiet("rst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

    // row 5, alternating bits -> every word 16'hAAAA at 100..119
    clear_mon();
    row_go(8'd5, alt_row());
    wait_idle("t1");
    chk_row("t1", 100, {20{16'hAAAA}});
    chk("t1_rowdone", 32'(done_cnt), 32'd1);
    chk("t1_ovr", 32'(overrun), 32'd0);

    // last legal row ends at 4799; row 240 is discarded
    clear_mon();
    row_go(8'd239, mk_row(16'h2000));
    wait_idle("t2a");
    chk_row("t2a", 4780, mk_row(16'h2000));
    chk("t2a_rowdone", 32'(done_cnt), 32'd1);
    clear_mon();
    row_go(8'd240, mk_row(16'h3000));
    wait_idle("t2b");
    chk("t2b_nwr", 32'(cap_addr.size()), 32'd0);
    chk("t2b_rowdone", 32'(done_cnt), 32'd0);
    chk("t2b_busy_cyc", 32'(busy_cnt), 32'd2);

    // random backpressure on row 1
    clear_mon();
    rnd_rdy = 1'b1;
    row_go(8'd1, mk_row(16'h4000));
    wait_idle("t3");
    rnd_rdy = 1'b0;
    chk_row("t3", 20, mk_row(16'h4000));
    chk("t3_hold", 32'(hold_err), 32'd0);
    chk("t3_rowdone", 32'(done_cnt), 32'd1);

    // second edge lands while row 3 is writing
    clear_mon();
    row_go(8'd3, mk_row(16'h5000));
    repeat (2) begin @(posedge clk); #1; end
    row_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    row_ready = 1'b1;
    wait_idle("t4");
    chk_row("t4", 60, mk_row(16'h5000));
    chk("t4_rowdone", 32'(done_cnt), 32'd1);
    chk("t4_ovr", 32'(overrun), 32'd1);
    repeat (10) begin @(posedge clk); #1; end
    chk("t4_ovr_sticky", 32'(overrun), 32'd1);
`ifdef ROW_PACKER_DROP_CNT_EN
    chk("t4_drop1", 32'(drop_count), 32'd1);
    clear_mon();
    rdy_val = 1'b0;
    row_go(8'd7, mk_row(16'h7000));
    repeat (8) begin @(posedge clk); #1; end
    for (int i = 0; i < 300; i++) begin
      row_ready = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      row_ready = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
    end
    repeat (2) begin @(posedge clk); #1; end
    chk("t4_drop_sat", 32'(drop_count), 32'd255);
    rdy_val = 1'b1;
    wait_idle("t4c");
    chk_row("t4c", 140, mk_row(16'h7000));
`endif

    // reset while word 7 of row 2 is presented
    clear_mon();
    rdy_val = 1'b1;
    row_go(8'd2, mk_row(16'h6000));
    n = 0;
    while (cap_addr.size() < 7 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_reach_w7", 32'(cap_addr.size()), 32'd7);
    rst_n = 1'b0;
    #1;
    chk_quiet("t5_rst");
    row_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    clear_mon();
    row_go(8'd2, mk_row(16'h6000));
    wait_idle("t5");
    chk_row("t5", 40, mk_row(16'h6000));

    // row_ready high across reset release: ignored until a fresh rise
    @(posedge clk); #1;
    rst_n     = 1'b0;
    row_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
    repeat (20) begin @(posedge clk); #1; end
    chk("t6_nwr_held", 32'(cap_addr.size()), 32'd0);
    chk("t6_busy_held", 32'(busy_cnt), 32'd0);
    row_ready = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    row_ready = 1'b1;
    n = 0;
    while (n < 50) begin
      @(posedge clk);
      n++;
      #1;
      if (mem_if.mem_we === 1'b1) break;
    end
    chk("t6_latency", 32'(n), 32'd5);
    wait_idle("t6");
    chk_row("t6", 40, mk_row(16'h6000));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
